// File: rtl/word_tx.sv
// Word-to-byte serializer: takes 32-bit words over valid/ready and sends them
// LSB first as four bytes to the UART transmitter, paced by byte_done.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | nothing in flight; move the holding register into shift if full
// ST_SEND | one-cycle byte_start for shift[7:0]
// ST_WAIT | waiting for the transmitter's byte_done
// ST_GAP  | inter-byte idle cycles, counted down in gap_cnt
// ST_DONE | one-cycle word_sent; chain straight into the pending word if any
module word_tx #(
    parameter int BYTE_GAP = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    output logic [7:0]  byte_out,
    output logic        byte_start,
    input  logic        byte_done,
    output logic        word_sent,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam bit         HAS_GAP  = (BYTE_GAP > 0);
    localparam logic [7:0] GAP_LOAD = HAS_GAP ? 8'(BYTE_GAP - 1) : 8'd0;

    state_t      state_q, state_d;
    logic [31:0] pending_q, pending_d;
    logic        pending_valid_q, pending_valid_d;
    logic [31:0] shift_q, shift_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            pending_q       <= 32'h0;
            pending_valid_q <= 1'b0;
            shift_q         <= 32'h0;
            byte_idx_q      <= 2'd0;
            gap_cnt_q       <= 8'd0;
        end else begin
            state_q         <= state_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            shift_q         <= shift_d;
            byte_idx_q      <= byte_idx_d;
            gap_cnt_q       <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        shift_d         = shift_q;
        byte_idx_d      = byte_idx_q;
        gap_cnt_d       = gap_cnt_q;
        byte_start      = 1'b0;
        word_sent       = 1'b0;

        // Accept and transfer are mutually exclusive: one needs the holding
        // register empty, the other needs it full.
        if (word_valid && !pending_valid_q) begin
            pending_d       = word_in;
            pending_valid_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (pending_valid_q) begin
                    shift_d         = pending_q;
                    pending_valid_d = 1'b0;
                    byte_idx_d      = 2'd0;
                    state_d         = ST_SEND;
                end
            end
            ST_SEND: begin
                byte_start = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (byte_done) begin
                    if (byte_idx_q == 2'd3) begin
                        state_d = ST_DONE;
                    end else begin
                        shift_d    = {8'h00, shift_q[31:8]};
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (HAS_GAP) begin
                            gap_cnt_d = GAP_LOAD;
                            state_d   = ST_GAP;
                        end else begin
                            state_d = ST_SEND;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 8'd0) begin
                    state_d = ST_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            ST_DONE: begin
                word_sent = 1'b1;
                if (pending_valid_q) begin
                    shift_d         = pending_q;
                    pending_valid_d = 1'b0;
                    byte_idx_d      = 2'd0;
                    state_d         = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign word_ready = !pending_valid_q;
    assign byte_out   = shift_q[7:0];
    assign busy       = (state_q != ST_IDLE) || pending_valid_q;

endmodule

// File: tb/tb_word_tx.sv
// Bench for word_tx: two instances (no gap and BYTE_GAP=3) driven with random
// words and checked against a word-queue model of the byte stream and its timing.
module tb_word_tx;

    localparam int GAP1 = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wi [2];
    logic        wv [2];
    logic        wr [2];
    logic [7:0]  bo [2];
    logic        bs [2];
    logic        bd [2];
    logic        ws [2];
    logic        by [2];

    logic        resp [2];
    logic        spur_idle [2];
    bit          spur_send [2];
    bit          spur_gap [2];
    int          lat [2];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bd[0] = resp[0] | spur_idle[0];
    assign bd[1] = resp[1] | spur_idle[1];

    word_tx #(.BYTE_GAP(0)) u_tx0 (
        .clk(clk), .rst_n(rst_n), .word_in(wi[0]), .word_valid(wv[0]),
        .word_ready(wr[0]), .byte_out(bo[0]), .byte_start(bs[0]),
        .byte_done(bd[0]), .word_sent(ws[0]), .busy(by[0])
    );

    word_tx #(.BYTE_GAP(GAP1)) u_tx3 (
        .clk(clk), .rst_n(rst_n), .word_in(wi[1]), .word_valid(wv[1]),
        .word_ready(wr[1]), .byte_out(bo[1]), .byte_start(bs[1]),
        .byte_done(bd[1]), .word_sent(ws[1]), .busy(by[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Reference model: words accepted but not yet started, plus the word in flight.
    logic [31:0] nq [2][$];
    int          aq [2][$];
    logic [31:0] cur [2];
    int          midx [2];
    int          wait_from [2];
    int          last_done [2];
    int          last_sent [2];
    int          exp_sent [2];
    int          starts_seen [2];
    int          sents_seen [2];
    bit          waiting [2];
    bit          active [2];
    int          m_a, m_e, m_gap;

    initial begin
        for (int u = 0; u < 2; u++) begin
            starts_seen[u] = 0;
            sents_seen[u]  = 0;
            midx[u]        = 0;
            waiting[u]     = 1'b0;
            active[u]      = 1'b0;
            exp_sent[u]    = -1;
            last_sent[u]   = -1000;
            last_done[u]   = -1000;
            wait_from[u]   = 0;
            cur[u]         = 32'h0;
        end
    end

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            m_gap = (u == 0) ? 0 : GAP1;
            if (!rst_n) begin
                nq[u].delete();
                aq[u].delete();
                midx[u]      = 0;
                waiting[u]   = 1'b0;
                active[u]    = 1'b0;
                exp_sent[u]  = -1;
                last_sent[u] = -1000;
                last_done[u] = -1000;
            end else begin
                if (bs[u]) begin
                    starts_seen[u]++;
                    if (midx[u] == 0) begin
                        chk($sformatf("u%0d_start_has_word", u), 32'(nq[u].size()), 32'd1);
                        if (nq[u].size() != 0) begin
                            cur[u] = nq[u].pop_front();
                            m_a    = aq[u].pop_front();
                            m_e    = (m_a + 2 > last_sent[u] + 1) ? m_a + 2 : last_sent[u] + 1;
                            chk($sformatf("u%0d_first_start_cycle", u), cyc, m_e);
                            active[u] = 1'b1;
                        end
                    end else begin
                        chk($sformatf("u%0d_next_start_cycle", u), cyc, last_done[u] + 1 + m_gap);
                    end
                    chk($sformatf("u%0d_byte%0d_value", u, midx[u]), 32'(bo[u]),
                        32'(cur[u][8*midx[u] +: 8]));
                    waiting[u]   = 1'b1;
                    wait_from[u] = cyc + 1;
                end else if (waiting[u]) begin
                    chk($sformatf("u%0d_byte_hold", u), 32'(bo[u]), 32'(cur[u][8*midx[u] +: 8]));
                end

                chk($sformatf("u%0d_word_ready", u), 32'(wr[u]), 32'(nq[u].size() == 0));
                chk($sformatf("u%0d_busy", u), 32'(by[u]),
                    32'(nq[u].size() != 0 || active[u] || cyc == exp_sent[u]));
                if (ws[u] || cyc == exp_sent[u])
                    chk($sformatf("u%0d_word_sent", u), 32'(ws[u]), 32'(cyc == exp_sent[u]));
                if (cyc == exp_sent[u]) begin
                    last_sent[u] = cyc;
                    sents_seen[u]++;
                end

                if (bd[u] && waiting[u] && cyc >= wait_from[u]) begin
                    waiting[u]   = 1'b0;
                    last_done[u] = cyc;
                    if (midx[u] == 3) begin
                        midx[u]     = 0;
                        active[u]   = 1'b0;
                        exp_sent[u] = cyc + 1;
                    end else begin
                        midx[u]++;
                    end
                end

                if (wv[u] && nq[u].size() == 0) begin
                    nq[u].push_back(wi[u]);
                    aq[u].push_back(cyc);
                end
            end
        end
    end

    // UART stand-in: byte_done lat[u] cycles after each byte_start, with
    // optional extra pulses in the SEND cycle or the cycle after a done.
    int  cnt [2];
    int  bidx [2];
    bit  sg [2];

    initial begin
        for (int u = 0; u < 2; u++) begin
            resp[u] = 1'b0;
            cnt[u]  = 0;
            bidx[u] = 0;
            sg[u]   = 1'b0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int u = 0; u < 2; u++) begin
                resp[u] = 1'b0;
                if (!rst_n) begin
                    cnt[u]  = 0;
                    bidx[u] = 0;
                    sg[u]   = 1'b0;
                end else begin
                    if (sg[u]) begin
                        resp[u] = 1'b1;
                        sg[u]   = 1'b0;
                    end
                    if (cnt[u] > 0) begin
                        cnt[u]--;
                        if (cnt[u] == 0) begin
                            resp[u] = 1'b1;
                            if (spur_gap[u] && bidx[u] != 3) sg[u] = 1'b1;
                            bidx[u] = (bidx[u] + 1) % 4;
                        end
                    end
                    if (bs[u]) begin
                        cnt[u] = lat[u];
                        if (spur_send[u]) resp[u] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input int u, input logic [31:0] w, input bit scramble, output int acc);
        wi[u] = w;
        wv[u] = 1'b1;
        acc   = -1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (wr[u]) begin
                acc = cyc;
                break;
            end
            @(posedge clk);
            #1;
            if (scramble) wi[u] = $urandom;
        end
        @(posedge clk);
        #1;
        wv[u] = 1'b0;
        chk($sformatf("u%0d_send_accepted", u), 32'(acc >= 0), 32'd1);
    endtask

    task automatic wait_idle(input int u);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            tick();
            if (nq[u].size() == 0 && !active[u] && cyc > exp_sent[u] + 1) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("u%0d_idle_reached", u), 32'(ok), 32'd1);
    endtask

    task automatic chk_reset_outs(input int u, input string pfx);
        chk($sformatf("%s_u%0d_word_ready", pfx, u), 32'(wr[u]), 32'd1);
        chk($sformatf("%s_u%0d_byte_start", pfx, u), 32'(bs[u]), 32'd0);
        chk($sformatf("%s_u%0d_word_sent", pfx, u), 32'(ws[u]), 32'd0);
        chk($sformatf("%s_u%0d_busy", pfx, u), 32'(by[u]), 32'd0);
        chk($sformatf("%s_u%0d_byte_out", pfx, u), 32'(bo[u]), 32'd0);
    endtask

    int  a1, a2, s, s2;
    bit  found;

    initial begin
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            wi[u]        = 32'h0;
            wv[u]        = 1'b0;
            spur_idle[u] = 1'b0;
            spur_send[u] = 1'b0;
            spur_gap[u]  = 1'b0;
            lat[u]       = 5;
        end
        tick();
        tick();
        chk_reset_outs(0, "por");
        chk_reset_outs(1, "por");
        rst_n = 1'b1;
        repeat (2) tick();

        // Single word, byte_done 5 cycles after each byte_start
        send_word(0, 32'hDDCCBBAA, 1'b0, a1);
        s = sents_seen[0];
        wait_idle(0);
        chk("single_word_sent_pulses", 32'(sents_seen[0] - s), 32'd1);

        // Back-to-back words
        send_word(0, 32'h11223344, 1'b0, a1);
        send_word(0, 32'h55667788, 1'b0, a2);
        chk("b2b_accept_spacing", 32'(a2 - a1), 32'd2);
        wait_idle(0);

        // Spurious byte_done while idle
        s = starts_seen[0];
        spur_idle[0] = 1'b1;
        tick();
        spur_idle[0] = 1'b0;
        repeat (5) tick();
        chk("idle_spur_busy", 32'(by[0]), 32'd0);
        chk("idle_spur_starts", 32'(starts_seen[0] - s), 32'd0);

        // Spurious byte_done in every SEND cycle
        spur_send[0] = 1'b1;
        send_word(0, $urandom, 1'b0, a1);
        wait_idle(0);
        spur_send[0] = 1'b0;

        // Valid held while not ready, data changing every cycle
        send_word(0, 32'hCAFEF00D, 1'b0, a1);
        send_word(0, $urandom, 1'b1, a2);
        wait_idle(0);

        // Random traffic on the no-gap instance
        for (int i = 0; i < 25; i++) begin
            lat[0]       = $urandom_range(1, 8);
            spur_send[0] = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 10)) tick();
            send_word(0, $urandom, 1'(($urandom_range(0, 1))), a1);
        end
        wait_idle(0);
        spur_send[0] = 1'b0;
        lat[0]       = 5;

        // Gap instance: plain word, then back-to-back with spurious done in GAP
        send_word(1, 32'h44332211, 1'b0, a1);
        wait_idle(1);
        spur_gap[1] = 1'b1;
        send_word(1, 32'h99AABBCC, 1'b0, a1);
        send_word(1, 32'h01020304, 1'b0, a2);
        wait_idle(1);
        for (int i = 0; i < 10; i++) begin
            lat[1]      = $urandom_range(1, 6);
            spur_gap[1] = ($urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 6)) tick();
            send_word(1, $urandom, 1'(($urandom_range(0, 1))), a1);
        end
        wait_idle(1);
        spur_gap[1] = 1'b0;

        // Reset during WAIT of byte 2 with a word pending
        lat[0] = 8;
        send_word(0, 32'hA1B2C3D4, 1'b0, a1);
        send_word(0, 32'h0BADBEEF, 1'b0, a2);
        found = 1'b0;
        for (int n = 0; n < 300; n++) begin
            tick();
            if (midx[0] == 2 && waiting[0] && cyc > wait_from[0] && nq[0].size() == 1) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_reached_byte2_wait", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs(0, "midword_rst");
        repeat (3) tick();
        rst_n = 1'b1;
        s = starts_seen[0];
        repeat (20) tick();
        chk("rst_no_start_after_release", 32'(starts_seen[0] - s), 32'd0);
        chk("rst_ready_after_release", 32'(wr[0]), 32'd1);
        lat[0] = 3;
        send_word(0, 32'h76543210, 1'b0, a1);
        s2 = sents_seen[0];
        wait_idle(0);
        chk("rst_new_word_sent", 32'(sents_seen[0] - s2), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
